// File: rtl/nn_fixed_pkg.sv
// Fixed-point widths, FSM state encoding and the Q24.16 -> Q16.16 saturator
// shared by the neuron accumulator.
package nn_fixed_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned FRAC_W = 8;
  localparam int unsigned OUT_W  = 32;
  localparam int unsigned ACC_W  = 40;
  localparam int unsigned IDX_W  = 32;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  typedef struct packed {
    logic [OUT_W-1:0] value;
    logic             sat;
  } sat_t;

  // The value fits when every bit from the OUT_W sign bit upward agrees.
  function automatic sat_t saturate(input logic [ACC_W-1:0] a);
    sat_t r;
    if (a[ACC_W-1:OUT_W-1] == {(ACC_W-OUT_W+1){1'b0}} ||
        a[ACC_W-1:OUT_W-1] == {(ACC_W-OUT_W+1){1'b1}}) begin
      r.value = a[OUT_W-1:0];
      r.sat   = 1'b0;
    end else if (a[ACC_W-1]) begin
      r.value = {1'b1, {(OUT_W-1){1'b0}}};
      r.sat   = 1'b1;
    end else begin
      r.value = {1'b0, {(OUT_W-1){1'b1}}};
      r.sat   = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/neuron_mac_if.sv
// Control, input-stream and result-stream signals of the neuron accumulator.
interface neuron_mac_if;
  import nn_fixed_pkg::*;

  logic              start;
  logic [CNT_W-1:0]  n_inputs;
  logic [DATA_W-1:0] bias;
  logic [IDX_W-1:0]  neuron_idx;
  logic              layer_sel;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] w;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  act_out;
  logic [IDX_W-1:0]  out_idx;
  logic              out_layer;
  logic              sat;
  logic              busy;

  modport master (
    output start, n_inputs, bias, neuron_idx, layer_sel, in_valid, x, w, out_ready,
    input  in_ready, out_valid, act_out, out_idx, out_layer, sat, busy
  );

  modport slave (
    input  start, n_inputs, bias, neuron_idx, layer_sel, in_valid, x, w, out_ready,
    output in_ready, out_valid, act_out, out_idx, out_layer, sat, busy
  );

endinterface

// File: rtl/mac_pipe.sv
// Product register and Q24.16 accumulator. The pending product is folded in one
// cycle after it is captured; acc_next exposes the value the accumulator takes next.
module mac_pipe
  import nn_fixed_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] bias,
  input  logic              fire,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] w,
  output logic [ACC_W-1:0]  acc_next
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] xs, ws, prod;
  logic [PROD_W-1:0]        p_q;
  logic                     p_vld_q;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [ACC_W-1:0]         bias_aligned;

  always_comb begin
    xs   = {{DATA_W{x[DATA_W-1]}}, x};
    ws   = {{DATA_W{w[DATA_W-1]}}, w};
    prod = xs * ws;
  end

  // Q8.8 bias shifted into Q24.16.
  assign bias_aligned = {{(ACC_W-DATA_W-FRAC_W){bias[DATA_W-1]}}, bias, {FRAC_W{1'b0}}};

  always_comb begin
    acc_d = acc_q;
    if (p_vld_q) begin
      acc_d = acc_q + {{(ACC_W-PROD_W){p_q[PROD_W-1]}}, p_q};
    end
  end

  assign acc_next = acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      p_q     <= '0;
      p_vld_q <= 1'b0;
    end else if (load) begin
      acc_q   <= bias_aligned;
      p_q     <= '0;
      p_vld_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      p_vld_q <= fire;
      if (fire) begin
        p_q <= prod;
      end
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Streaming neuron accumulator: bias + sum(x*w) in fixed point, saturated to Q16.16,
// with valid/ready on both the pair input and the result output.
module neuron_mac
  import nn_fixed_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  neuron_mac_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] n_q;
  logic [IDX_W-1:0] idx_q;
  logic             layer_q;
  logic [OUT_W-1:0] act_q;
  logic             sat_q;

  logic             load;
  logic             hs_in;
  logic             hs_out;
  logic [ACC_W-1:0] acc_next;
  sat_t             sat_res;

  assign load    = (state_q == IDLE) && bus.start;
  assign hs_in   = (state_q == ACCUM) && bus.in_valid;
  assign hs_out  = (state_q == OUT) && bus.out_ready;
  assign sat_res = saturate(acc_next);

  mac_pipe u_mac_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .bias     (bus.bias),
    .fire     (hs_in),
    .x        (bus.x),
    .w        (bus.w),
    .acc_next (acc_next)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = (bus.n_inputs != '0) ? ACCUM : DRAIN;
        end
      end
      ACCUM: begin
        if (hs_in && (cnt_q == n_q - 8'd1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = OUT;
      OUT: begin
        if (hs_out) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      layer_q <= 1'b0;
      act_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        cnt_q   <= '0;
        n_q     <= bus.n_inputs;
        idx_q   <= bus.neuron_idx;
        layer_q <= bus.layer_sel;
      end else if (hs_in) begin
        cnt_q <= cnt_q + 8'd1;
      end
      // acc_next already includes the last pending product while draining.
      if (state_q == DRAIN) begin
        act_q <= sat_res.value;
        sat_q <= sat_res.sat;
      end
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == OUT);
  assign bus.busy      = (state_q != IDLE);
  assign bus.act_out   = act_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_layer = layer_q;
  assign bus.sat       = sat_q;

endmodule
